// File: rtl/dft_load_datapath.sv
// dft_load_datapath
// Scan-load datapath: buffers 32-bit host words arriving on a valid/ack
// handshake, then on command shifts them serially into the scan chain with
// scan enable asserted, and ends with a one-cycle commit pulse.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high; clears all control state
//   dft_in         parallel word to load
//   buf_val_op     dft_in valid (write request)
//   buf_op         start shifting the buffer out
//   buf_op_ack     one-cycle pulse: previous-cycle word accepted
//   buf_scaning    high while shifting
//   buf_op_commit  one-cycle pulse: shift operation complete
//   sc_sen         scan enable to the chain
//   dft_sout       serial scan data to the chain
//   buf_count      number of words stored
//
// Build option: define DFT_LOAD_MSB_FIRST_EN to shift each word MSB-first
// (default LSB-first). Word order is always oldest word first.
module dft_load_datapath #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [31:0]                        dft_in,
  input  logic                               buf_val_op,
  input  logic                               buf_op,
  output logic                               buf_op_ack,
  output logic                               buf_scaning,
  output logic                               buf_op_commit,
  output logic                               sc_sen,
  output logic                               dft_sout,
  output logic [$clog2(DEPTH_WORDS+1)-1:0]   buf_count
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam int CW     = $clog2(DEPTH_WORDS + 1);
  localparam logic [AW-1:0] WORD0 = '0;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [AW-1:0]     wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic [AW-1:0]     cur_word_q;
  logic [4:0]        cur_bit_q;
  logic              ack_q;
  logic              commit_q;
  logic              sen_q;
  logic              sout_q;

  logic [AW-1:0]     nxt_word_d;
  logic [4:0]        nxt_bit_d;
  logic              last_bit;
  logic              last_word;
  logic              wr_en;

  // Selects the bit of a word that goes out at a given position.
  function automatic logic pick_bit(input logic [DATA_W-1:0] w,
                                    input logic [4:0] pos);
`ifdef DFT_LOAD_MSB_FIRST_EN
    return w[5'd31 - pos];
`else
    return w[pos];
`endif
  endfunction

  // cur_word_q/cur_bit_q track the bit currently on dft_sout; the next
  // position is precomputed so the output register is loaded directly.
  always_comb begin
    last_bit   = (cur_bit_q == 5'd31);
    last_word  = (CW'(cur_word_q) == (count_q - CW'(1)));
    nxt_bit_d  = cur_bit_q + 5'd1;
    nxt_word_d = cur_word_q + AW'(last_bit);
    // buf_op wins over a simultaneous write; full buffer drops the word.
    wr_en      = (state_q == IDLE) && buf_val_op && !buf_op &&
                 (count_q < CW'(DEPTH_WORDS));
  end

  // Word storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= dft_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      cur_word_q <= '0;
      cur_bit_q  <= '0;
      ack_q      <= 1'b0;
      commit_q   <= 1'b0;
      sen_q      <= 1'b0;
      sout_q     <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      commit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (buf_op) begin
            if (count_q != '0) begin
              state_q    <= SHIFT;
              sen_q      <= 1'b1;
              cur_word_q <= '0;
              cur_bit_q  <= '0;
              sout_q     <= pick_bit(mem_q[WORD0], 5'd0);
            end else begin
              state_q  <= DONE;
              commit_q <= 1'b1;
            end
          end else if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            count_q  <= count_q + CW'(1);
            ack_q    <= 1'b1;
          end
        end
        SHIFT: begin
          if (last_bit && last_word) begin
            state_q  <= DONE;
            sen_q    <= 1'b0;
            sout_q   <= 1'b0;
            commit_q <= 1'b1;
          end else begin
            cur_bit_q  <= nxt_bit_d;
            cur_word_q <= nxt_word_d;
            sout_q     <= pick_bit(mem_q[nxt_word_d], nxt_bit_d);
          end
        end
        DONE: begin
          state_q    <= IDLE;
          count_q    <= '0;
          wr_ptr_q   <= '0;
          cur_word_q <= '0;
          cur_bit_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign buf_op_ack    = ack_q;
  assign buf_op_commit = commit_q;
  assign sc_sen        = sen_q;
  assign buf_scaning   = sen_q;
  assign dft_sout      = sout_q;
  assign buf_count     = count_q;

endmodule
